// File: rtl/cvxif_copro_exec.sv
// Two-stage CV-X-IF coprocessor execution unit with credit-throttled result FIFO.
// Optional CVXIF_CHACHA_EN macro enables the OP_CHACHA datapath (otherwise it decodes as illegal).
module cvxif_copro_exec #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned IdWidth     = 4,
  parameter int unsigned ResultDepth = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  input  logic               issue_valid_i,
  output logic               issue_ready_o,
  input  logic [3:0]         opcode_i,
  input  logic [IdWidth-1:0] id_i,
  input  logic [4:0]         rd_i,
  input  logic               writeback_i,
  input  logic [5:0]         rot_amt_i,
  input  logic [1:0]         rot_sel_i,
  input  logic [XLEN-1:0]    rs1_i,
  input  logic [XLEN-1:0]    rs2_i,
  input  logic [XLEN-1:0]    rs3_i,
  output logic               result_valid_o,
  input  logic               result_ready_i,
  output logic [IdWidth-1:0] result_id_o,
  output logic [4:0]         result_rd_o,
  output logic [XLEN-1:0]    result_data_o,
  output logic               result_we_o,
  output logic               result_exc_o,
  output logic               busy_o
);

  // opcode_t encoding shared with the decoder
  localparam logic [3:0] OpIllegal = 4'd0;
  localparam logic [3:0] OpNop     = 4'd1;
  localparam logic [3:0] OpRor64h  = 4'd2;
  localparam logic [3:0] OpRor64l  = 4'd3;
  localparam logic [3:0] OpAscon   = 4'd4;
  localparam logic [3:0] OpChacha  = 4'd5;

  localparam int unsigned PtrW = (ResultDepth > 1) ? $clog2(ResultDepth) : 1;
  localparam int unsigned CntW = $clog2(ResultDepth + 1);

  logic               issue_accept;
  logic               pop;
  logic [CntW:0]      credits_used;

  logic               s1_valid_q;
  logic [IdWidth-1:0] s1_id_q;
  logic [4:0]         s1_rd_q;
  logic [3:0]         s1_op_q;
  logic               s1_wb_q;
  logic [5:0]         s1_rot_q;
  logic [XLEN-1:0]    s1_a_q, s1_b_q, s1_c_q;
  logic [XLEN-1:0]    s1_a_d;

  logic [XLEN-1:0]    s2_data;
  logic               s2_we;
  logic               s2_exc;
  logic [2*XLEN-1:0]  ror_cat;
  logic [2*XLEN-1:0]  ror_res;

  logic [IdWidth-1:0] fifo_id_q   [ResultDepth];
  logic [4:0]         fifo_rd_q   [ResultDepth];
  logic [XLEN-1:0]    fifo_data_q [ResultDepth];
  logic               fifo_we_q   [ResultDepth];
  logic               fifo_exc_q  [ResultDepth];
  logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]    fifo_cnt_q;

  // S1 plus FIFO occupancy is the outstanding credit count
  assign credits_used  = {1'b0, fifo_cnt_q} + {{CntW{1'b0}}, s1_valid_q};
  assign issue_ready_o = !flush_i && (credits_used < (CntW + 1)'(ResultDepth));
  assign issue_accept  = issue_valid_i && issue_ready_o;

`ifdef CVXIF_CHACHA_EN
  logic [1:0] s1_sel_q;

  function automatic logic [XLEN-1:0] rotl(input logic [XLEN-1:0] v, input int unsigned n);
    return (v << n) | (v >> (XLEN - n));
  endfunction

  // ChaCha add/xor is folded into S1 so S2 only has to rotate
  assign s1_a_d = (opcode_i == OpChacha) ? ((rs1_i + rs2_i) ^ rs3_i) : rs1_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_sel_q <= '0;
    end else if (issue_accept) begin
      s1_sel_q <= rot_sel_i;
    end
  end
`else
  logic unused_rot_sel;
  assign unused_rot_sel = ^rot_sel_i;
  assign s1_a_d         = rs1_i;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q <= 1'b0;
      s1_id_q    <= '0;
      s1_rd_q    <= '0;
      s1_op_q    <= OpIllegal;
      s1_wb_q    <= 1'b0;
      s1_rot_q   <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_c_q     <= '0;
    end else if (flush_i) begin
      s1_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= issue_accept;
      if (issue_accept) begin
        s1_id_q  <= id_i;
        s1_rd_q  <= rd_i;
        s1_op_q  <= opcode_i;
        s1_wb_q  <= writeback_i;
        s1_rot_q <= rot_amt_i;
        s1_a_q   <= s1_a_d;
        s1_b_q   <= rs2_i;
        s1_c_q   <= rs3_i;
      end
    end
  end

  assign ror_cat = {s1_b_q, s1_a_q};
  assign ror_res = (ror_cat >> s1_rot_q) | (ror_cat << ((2 * XLEN) - 32'(s1_rot_q)));

  always_comb begin
    s2_data = '0;
    s2_we   = s1_wb_q;
    s2_exc  = 1'b0;
    case (s1_op_q)
      OpNop:    s2_data = '0;
      OpRor64h: s2_data = ror_res[2*XLEN-1:XLEN];
      OpRor64l: s2_data = ror_res[XLEN-1:0];
      OpAscon:  s2_data = s1_a_q ^ (~s1_b_q & s1_c_q);
`ifdef CVXIF_CHACHA_EN
      OpChacha: begin
        case (s1_sel_q)
          2'd0:    s2_data = rotl(s1_a_q, 16);
          2'd1:    s2_data = rotl(s1_a_q, 12);
          2'd2:    s2_data = rotl(s1_a_q, 8);
          default: s2_data = rotl(s1_a_q, 7);
        endcase
      end
`endif
      default: begin
        s2_we  = 1'b0;
        s2_exc = 1'b1;
      end
    endcase
  end

  assign pop = result_valid_o && result_ready_i;

  always_ff @(posedge clk_i) begin
    if (s1_valid_q && !flush_i) begin
      fifo_id_q[wr_ptr_q]   <= s1_id_q;
      fifo_rd_q[wr_ptr_q]   <= s1_rd_q;
      fifo_data_q[wr_ptr_q] <= s2_data;
      fifo_we_q[wr_ptr_q]   <= s2_we;
      fifo_exc_q[wr_ptr_q]  <= s2_exc;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else if (flush_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (s1_valid_q) begin
        wr_ptr_q <= (wr_ptr_q == PtrW'(ResultDepth - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PtrW'(ResultDepth - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      fifo_cnt_q <= fifo_cnt_q + CntW'(s1_valid_q) - CntW'(pop);
    end
  end

  assign result_valid_o = (fifo_cnt_q != '0);
  assign result_id_o    = result_valid_o ? fifo_id_q[rd_ptr_q]   : '0;
  assign result_rd_o    = result_valid_o ? fifo_rd_q[rd_ptr_q]   : '0;
  assign result_data_o  = result_valid_o ? fifo_data_q[rd_ptr_q] : '0;
  assign result_we_o    = result_valid_o && fifo_we_q[rd_ptr_q];
  assign result_exc_o   = result_valid_o && fifo_exc_q[rd_ptr_q];
  assign busy_o         = s1_valid_q || result_valid_o;

endmodule

// File: tb/tb_cvxif_copro_exec.sv
// Self-checking bench for cvxif_copro_exec: directed cases plus randomized traffic
// compared every cycle against a queue-based model of outstanding instructions.
module tb_cvxif_copro_exec;

  localparam int unsigned Depth = 4;
  localparam logic [3:0] OpIllegal = 4'd0;
  localparam logic [3:0] OpNop     = 4'd1;
  localparam logic [3:0] OpRor64h  = 4'd2;
  localparam logic [3:0] OpRor64l  = 4'd3;
  localparam logic [3:0] OpAscon   = 4'd4;
  localparam logic [3:0] OpChacha  = 4'd5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        issue_valid;
  logic        issue_ready_o;
  logic [3:0]  opcode;
  logic [3:0]  id;
  logic [4:0]  rd;
  logic        wb;
  logic [5:0]  rot_amt;
  logic [1:0]  rot_sel;
  logic [31:0] rs1, rs2, rs3;
  logic        result_valid_o;
  logic        result_ready;
  logic [3:0]  result_id_o;
  logic [4:0]  result_rd_o;
  logic [31:0] result_data_o;
  logic        result_we_o;
  logic        result_exc_o;
  logic        busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cvxif_copro_exec #(
    .XLEN(32),
    .IdWidth(4),
    .ResultDepth(Depth)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .flush_i       (flush),
    .issue_valid_i (issue_valid),
    .issue_ready_o (issue_ready_o),
    .opcode_i      (opcode),
    .id_i          (id),
    .rd_i          (rd),
    .writeback_i   (wb),
    .rot_amt_i     (rot_amt),
    .rot_sel_i     (rot_sel),
    .rs1_i         (rs1),
    .rs2_i         (rs2),
    .rs3_i         (rs3),
    .result_valid_o(result_valid_o),
    .result_ready_i(result_ready),
    .result_id_o   (result_id_o),
    .result_rd_o   (result_rd_o),
    .result_data_o (result_data_o),
    .result_we_o   (result_we_o),
    .result_exc_o  (result_exc_o),
    .busy_o        (busy_o)
  );

  typedef struct {
    logic [3:0]  id;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        we;
    logic        exc;
    int          avail;
  } res_t;

  res_t q[$];
  int   cyc = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic res_t model_exec(input logic [3:0] op, input logic [3:0] i_id,
                                      input logic [4:0] i_rd, input logic i_wb,
                                      input logic [5:0] amt, input logic [1:0] sel,
                                      input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] c);
    res_t r;
    logic [63:0] x;
    logic [31:0] t;
    int n;
    r.id = i_id; r.rd = i_rd; r.data = '0; r.we = i_wb; r.exc = 1'b0; r.avail = 0;
    case (op)
      OpNop: r.data = '0;
      OpRor64h, OpRor64l: begin
        x = {b, a};
        for (int k = 0; k < int'(amt); k++) x = {x[0], x[63:1]};
        r.data = (op == OpRor64h) ? x[63:32] : x[31:0];
      end
      OpAscon: r.data = a ^ (~b & c);
`ifdef CVXIF_CHACHA_EN
      OpChacha: begin
        t = (a + b) ^ c;
        n = (sel == 2'd0) ? 16 : (sel == 2'd1) ? 12 : (sel == 2'd2) ? 8 : 7;
        for (int k = 0; k < n; k++) t = {t[30:0], t[31]};
        r.data = t;
      end
`endif
      default: begin
        r.we = 1'b0; r.exc = 1'b1; r.data = '0;
        t = '0; n = int'(sel);
      end
    endcase
    return r;
  endfunction

  // Model: each accepted instruction becomes visible one edge after its accept edge.
  bit   m_pop, m_acc;
  int   m_sz;
  res_t m_r;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      m_sz  = q.size();
      m_pop = result_ready && m_sz > 0 && q[0].avail <= cyc;
      m_acc = issue_valid && !flush && m_sz < Depth;
      cyc++;
      if (flush) begin
        q.delete();
      end else begin
        if (m_pop) void'(q.pop_front());
        if (m_acc) begin
          m_r = model_exec(opcode, id, rd, wb, rot_amt, rot_sel, rs1, rs2, rs3);
          m_r.avail = cyc + 1;
          q.push_back(m_r);
        end
      end
    end
  end

  bit ev;
  always @(negedge clk) begin
    if (rst_n) begin
      ev = q.size() > 0 && q[0].avail <= cyc;
      chk("issue_ready", issue_ready_o, !flush && q.size() < Depth);
      chk("result_valid", result_valid_o, ev);
      chk("busy", busy_o, q.size() > 0);
      if (ev) begin
        chk("result_id", result_id_o, q[0].id);
        chk("result_rd", result_rd_o, q[0].rd);
        chk("result_data", result_data_o, q[0].data);
        chk("result_we", result_we_o, q[0].we);
        chk("result_exc", result_exc_o, q[0].exc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [3:0] i_id, input logic [4:0] i_rd,
                       input logic i_wb, input logic [5:0] amt, input logic [1:0] sel,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    issue_valid = 1'b1; opcode = op; id = i_id; rd = i_rd; wb = i_wb;
    rot_amt = amt; rot_sel = sel; rs1 = a; rs2 = b; rs3 = c;
  endtask

  task automatic idle();
    issue_valid = 1'b0;
  endtask

  res_t pin;

  initial begin
    rst_n = 1'b0; flush = 1'b0; result_ready = 1'b1;
    drive(OpNop, 0, 0, 0, 0, 0, 0, 0, 0);
    idle();

    pin = model_exec(OpAscon, 0, 0, 1, 0, 0, 32'hFFFF0000, 32'h0F0F0F0F, 32'h00FF00FF);
    chk("model_ascon", pin.data, 32'hFF0F00F0);
    pin = model_exec(OpRor64l, 0, 0, 1, 6'd4, 0, 32'h0, 32'h1, 32'h0);
    chk("model_ror_l", pin.data, 32'h10000000);
    pin = model_exec(OpIllegal, 0, 0, 1, 0, 0, 32'h5, 32'h6, 32'h7);
    chk("model_illegal", {pin.exc, pin.we}, 2'b10);

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", issue_ready_o, 1);
    chk("rst_valid", result_valid_o, 0);
    chk("rst_data", result_data_o, 0);
    chk("rst_id", result_id_o, 0);
    chk("rst_rd", result_rd_o, 0);
    chk("rst_we_exc", {result_we_o, result_exc_o}, 0);
    chk("rst_busy", busy_o, 0);

    // ASCON with latency pin
    tick();
    drive(OpAscon, 4'd1, 5'd3, 1, 0, 0, 32'hFFFF0000, 32'h0F0F0F0F, 32'h00FF00FF);
    tick();
    idle();
    @(negedge clk);
    chk("ascon_not_yet", result_valid_o, 0);
    @(negedge clk);
    chk("ascon_valid", result_valid_o, 1);
    chk("ascon_data", result_data_o, 32'hFF0F00F0);
    chk("ascon_we", result_we_o, 1);

    // ROR64L then ROR64H
    tick();
    drive(OpRor64l, 4'd2, 5'd4, 1, 6'd4, 0, 32'h0, 32'h1, 32'h0);
    tick();
    drive(OpRor64h, 4'd3, 5'd5, 1, 6'd4, 0, 32'h0, 32'h1, 32'h0);
    tick();
    idle();
    @(negedge clk);
    chk("rorl_id", result_id_o, 4'd2);
    chk("rorl_data", result_data_o, 32'h10000000);
    @(negedge clk);
    chk("rorh_id", result_id_o, 4'd3);
    chk("rorh_data", result_data_o, 32'h0);

    // Illegal opcode then CHACHA
    tick();
    drive(OpIllegal, 4'd8, 5'd1, 1, 0, 0, 32'h1234, 32'h5678, 32'h9ABC);
    tick();
    drive(OpChacha, 4'd9, 5'd2, 1, 0, 2'd0, 32'h1, 32'h2, 32'hF);
    tick();
    idle();
    @(negedge clk);
    chk("illegal_res", {result_exc_o, result_we_o, result_data_o}, {2'b10, 32'h0});
    @(negedge clk);
`ifdef CVXIF_CHACHA_EN
    chk("chacha_res", {result_exc_o, result_we_o, result_data_o}, {2'b01, 32'h000C0000});
`else
    chk("chacha_res", {result_exc_o, result_we_o, result_data_o}, {2'b10, 32'h0});
`endif

    // Backpressure: four accepts fill all credits
    tick();
    result_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(OpNop, 4'(4 + i), 5'(i), 0, 0, 0, 32'(i), 0, 0);
      tick();
    end
    idle();
    result_ready = 1'b1;
    @(negedge clk);
    chk("bp_full_ready", issue_ready_o, 0);
    @(negedge clk);
    chk("bp_ready_back", issue_ready_o, 1);
    repeat (6) tick();

    // Flush with three in flight
    result_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(OpAscon, 4'(10 + i), 5'(i), 1, 0, 0, $urandom, $urandom, $urandom);
      tick();
    end
    idle();
    flush = 1'b1;
    @(negedge clk);
    chk("flush_blocks", issue_ready_o, 0);
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_state", {result_valid_o, busy_o, issue_ready_o}, 3'b001);

    // Async reset mid-stream
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(OpRor64l, 4'(13 + i), 5'(i), 1, 6'(i), 0, $urandom, $urandom, 0);
      tick();
    end
    idle();
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("areset_state", {result_valid_o, busy_o, issue_ready_o}, 3'b001);
    @(posedge clk);
    #1 rst_n = 1'b1;
    result_ready = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      tick();
      drive(4'($urandom_range(0, 7)), 4'($urandom), 5'($urandom), 1'($urandom),
            6'($urandom), 2'($urandom), $urandom, $urandom, $urandom);
      issue_valid  = ($urandom_range(0, 9) < 7);
      result_ready = (i < 800) ? 1'b1 : ($urandom_range(0, 9) < 6);
      flush        = ($urandom_range(0, 59) == 0);
      if (i == 1500 || i == 2400) begin
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
      end
    end
    tick();
    idle();
    flush = 1'b0;
    result_ready = 1'b1;
    repeat (10) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cvxif_copro_exec.md
# cvxif_copro_exec

In-order two-stage execution unit of the CV-X-IF example coprocessor; sits directly downstream of the instruction decoder and consumes its decoded `opcode_t` plus operands. Executes NOP, ROR64H/ROR64L, OP_ASCON and OP_CHACHA and returns one result per accepted instruction through a buffered valid/ready result port. Credit-based issue throttling guarantees the pipeline never stalls internally.

## Interface
- `XLEN`, 32: operand/result width.
- `IdWidth`, 4: instruction id width.
- `ResultDepth`, 4: result FIFO entries; also total credit count (≥3 for full throughput).
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  asynchronous active-low reset.
- `flush_i`  in  1  kill all in-flight and buffered instructions.
- `issue_valid_i`  in  1  decoded instruction valid.
- `issue_ready_o`  out  1  unit can accept.
- `opcode_i`  in  4  `opcode_t` from decoder.
- `id_i`  in  IdWidth  instruction id.
- `rd_i`  in  5  destination register.
- `writeback_i`  in  1  decoder `writeback` flag.
- `rot_amt_i`  in  6  rotate amount (instr[31:26]) for ROR64.
- `rot_sel_i`  in  2  instr[26:25] ChaCha rotate select.
- `rs1_i`, `rs2_i`, `rs3_i`  in  XLEN each  source operands.
- `result_valid_o`  out  1  result available.
- `result_ready_i`  in  1  core accepts result.
- `result_id_o`  out  IdWidth;  `result_rd_o`  out  5;  `result_data_o`  out  XLEN.
- `result_we_o`  out  1  write rd.
- `result_exc_o`  out  1  illegal instruction.
- `busy_o`  out  1  any instruction in pipeline or FIFO.

## Operation
- Accept on `issue_valid_i && issue_ready_o`. `issue_ready_o = !flush_i && (inflight + fifo_count) < ResultDepth`; inflight counts valid S1/S2 entries.
- S1 registers id, rd, opcode, writeback and computes ChaCha pre-value `t = (rs1 + rs2) mod 2^32 ^ rs3`; other operands registered as-is.
- S2 computes final data and pushes into the FIFO unconditionally (credits guarantee space).
- NOP: data 0, we = `writeback_i` (0 by decode table), exc 0.
- ROR64H/ROR64L: 64-bit `{rs2, rs1}` rotated right by `rot_amt_i`; H returns bits [63:32], L bits [31:0]; we = `writeback_i`.
- OP_ASCON: `rs1 ^ (~rs2 & rs3)`, bitwise.
- OP_CHACHA: `t` rotated left by 16/12/8/7 for `rot_sel_i` = 0/1/2/3.
- ILLEGAL or unlisted opcode: data 0, we 0, exc 1.
- FIFO: in-order, head drives result outputs; pop on `result_valid_o && result_ready_i`; push and pop same cycle allowed when full.
- `flush_i`: next edge clears S1, S2, FIFO and counts; issue blocked while high.

## Timing
- Reset values: `issue_ready_o`=1, `result_valid_o`=0, `result_*` data/id/rd/we/exc=0, `busy_o`=0.
- Latency: accept at edge N → `result_valid_o` high in cycle N+2 when FIFO empty.
- Throughput: 1 instr/cycle with `result_ready_i` held high and ResultDepth ≥3.
- Result outputs stable while `result_valid_o && !result_ready_i`.
- Reset mid-operation discards everything; no result emitted for lost instructions.
- Credit counter returns one credit per pop; simultaneous accept+pop leaves count unchanged.

## Configuration
- `CVXIF_CHACHA_EN` defined: OP_CHACHA executed as above.
- Undefined: ChaCha datapath removed; OP_CHACHA treated as ILLEGAL (data 0, we 0, exc 1).

## Test plan
- CHACHA, rs1=0x00000001, rs2=0x00000002, rs3=0x0000000F, rot_sel=0 → data 0x000C0000, we 1, exc 0, two cycles after accept.
- ROR64L then ROR64H, rs1=0x00000000, rs2=0x00000001, rot_amt=4 → data 0x10000000 then 0x00000000, ids in order.
- ASCON, rs1=0xFFFF0000, rs2=0x0F0F0F0F, rs3=0x00FF00FF → data 0xFF0F00F0.
- result_ready_i low, issue 4 back-to-back → `issue_ready_o` drops after 4th; raise ready → 4 results in id order, ready returns after first pop.
- Opcode 4'b0000 and (macro undefined) OP_CHACHA → we 0, exc 1, data 0.
- 3 in flight, assert flush_i one cycle → no results, `busy_o`=0, `issue_ready_o`=1 next cycle; async reset mid-stream → same.
